// File: rtl/ps2_morse_encoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module   : ps2_morse_encoder_if
// Brief    : Received-byte strobe and Morse keying outputs.
// Revision : 1.0
// ============================================================
interface ps2_morse_encoder_if;
  logic [7:0] ps2_received_data;
  logic       ps2_received_data_strb;
  logic       dit_out;
  logic       dah_out;
  logic       morse_code_out;

  modport master (
    output ps2_received_data,
    output ps2_received_data_strb,
    output dit_out,
    output dah_out,
    output morse_code_out
  );

  modport slave (
    input ps2_received_data,
    input ps2_received_data_strb,
    input dit_out,
    input dah_out,
    input morse_code_out
  );
endinterface
`default_nettype wire

// File: rtl/ps2_morse_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module   : ps2_morse_encoder
// Brief    : PS/2 set-2 receiver feeding a character FIFO keyed out as Morse.
// Revision : 1.0
// ============================================================
module ps2_morse_encoder #(
  parameter int BUFFER_LENGTH  = 10,
  parameter int UNIT_CYCLES    = 25000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  inout  wire                 ps2_clk,
  inout  wire                 ps2_data,
  ps2_morse_encoder_if.master bus
);

  localparam int c_PTR_W = (BUFFER_LENGTH > 1) ? $clog2(BUFFER_LENGTH) : 1;
  localparam int c_CNT_W = $clog2(BUFFER_LENGTH + 1);
  localparam int c_TMR_W = $clog2(4 * UNIT_CYCLES);
  localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(BUFFER_LENGTH - 1);
  localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(BUFFER_LENGTH);
  localparam logic [c_TO_W-1:0]  c_T_TIMEOUT = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_T_DIT     = c_TMR_W'(UNIT_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_T_DAH     = c_TMR_W'(3 * UNIT_CYCLES - 1);
  // The LOAD cycle that follows each gap is part of the gap, hence the -2.
  localparam logic [c_TMR_W-1:0] c_T_CHARGAP = c_TMR_W'(2 * UNIT_CYCLES - 2);
  localparam logic [c_TMR_W-1:0] c_T_WORDGAP = c_TMR_W'(4 * UNIT_CYCLES - 2);

  localparam logic [7:0] c_KEY_BREAK = 8'hF0;
  localparam logic [7:0] c_KEY_EXT   = 8'hE0;
  localparam logic [7:0] c_KEY_ENTER = 8'h5A;
  localparam logic [5:0] c_SPACE     = 6'd36;

  localparam logic [2:0] c_ST_IDLE    = 3'd0;
  localparam logic [2:0] c_ST_LOAD    = 3'd1;
  localparam logic [2:0] c_ST_ELEMENT = 3'd2;
  localparam logic [2:0] c_ST_ELEMGAP = 3'd3;
  localparam logic [2:0] c_ST_CHARGAP = 3'd4;
  localparam logic [2:0] c_ST_WORDGAP = 3'd5;

  // {valid, index}: A-Z -> 0..25, 0-9 -> 26..35, space -> 36.
  function automatic logic [6:0] scan_to_idx(input logic [7:0] code);
    case (code)
      8'h1C: scan_to_idx = {1'b1, 6'd0};   8'h32: scan_to_idx = {1'b1, 6'd1};
      8'h21: scan_to_idx = {1'b1, 6'd2};   8'h23: scan_to_idx = {1'b1, 6'd3};
      8'h24: scan_to_idx = {1'b1, 6'd4};   8'h2B: scan_to_idx = {1'b1, 6'd5};
      8'h34: scan_to_idx = {1'b1, 6'd6};   8'h33: scan_to_idx = {1'b1, 6'd7};
      8'h43: scan_to_idx = {1'b1, 6'd8};   8'h3B: scan_to_idx = {1'b1, 6'd9};
      8'h42: scan_to_idx = {1'b1, 6'd10};  8'h4B: scan_to_idx = {1'b1, 6'd11};
      8'h3A: scan_to_idx = {1'b1, 6'd12};  8'h31: scan_to_idx = {1'b1, 6'd13};
      8'h44: scan_to_idx = {1'b1, 6'd14};  8'h4D: scan_to_idx = {1'b1, 6'd15};
      8'h15: scan_to_idx = {1'b1, 6'd16};  8'h2D: scan_to_idx = {1'b1, 6'd17};
      8'h1B: scan_to_idx = {1'b1, 6'd18};  8'h2C: scan_to_idx = {1'b1, 6'd19};
      8'h3C: scan_to_idx = {1'b1, 6'd20};  8'h2A: scan_to_idx = {1'b1, 6'd21};
      8'h1D: scan_to_idx = {1'b1, 6'd22};  8'h22: scan_to_idx = {1'b1, 6'd23};
      8'h35: scan_to_idx = {1'b1, 6'd24};  8'h1A: scan_to_idx = {1'b1, 6'd25};
      8'h45: scan_to_idx = {1'b1, 6'd26};  8'h16: scan_to_idx = {1'b1, 6'd27};
      8'h1E: scan_to_idx = {1'b1, 6'd28};  8'h26: scan_to_idx = {1'b1, 6'd29};
      8'h25: scan_to_idx = {1'b1, 6'd30};  8'h2E: scan_to_idx = {1'b1, 6'd31};
      8'h36: scan_to_idx = {1'b1, 6'd32};  8'h3D: scan_to_idx = {1'b1, 6'd33};
      8'h3E: scan_to_idx = {1'b1, 6'd34};  8'h46: scan_to_idx = {1'b1, 6'd35};
      8'h29: scan_to_idx = {1'b1, c_SPACE};
      default: scan_to_idx = 7'd0;
    endcase
  endfunction

  // {element count, pattern}: pattern bit i is element i, 1 = dah.
  function automatic logic [7:0] morse_lut(input logic [5:0] idx);
    case (idx)
      6'd0:  morse_lut = {3'd2, 5'b00010};  6'd1:  morse_lut = {3'd4, 5'b00001};
      6'd2:  morse_lut = {3'd4, 5'b00101};  6'd3:  morse_lut = {3'd3, 5'b00001};
      6'd4:  morse_lut = {3'd1, 5'b00000};  6'd5:  morse_lut = {3'd4, 5'b00100};
      6'd6:  morse_lut = {3'd3, 5'b00011};  6'd7:  morse_lut = {3'd4, 5'b00000};
      6'd8:  morse_lut = {3'd2, 5'b00000};  6'd9:  morse_lut = {3'd4, 5'b01110};
      6'd10: morse_lut = {3'd3, 5'b00101};  6'd11: morse_lut = {3'd4, 5'b00010};
      6'd12: morse_lut = {3'd2, 5'b00011};  6'd13: morse_lut = {3'd2, 5'b00001};
      6'd14: morse_lut = {3'd3, 5'b00111};  6'd15: morse_lut = {3'd4, 5'b00110};
      6'd16: morse_lut = {3'd4, 5'b01011};  6'd17: morse_lut = {3'd3, 5'b00010};
      6'd18: morse_lut = {3'd3, 5'b00000};  6'd19: morse_lut = {3'd1, 5'b00001};
      6'd20: morse_lut = {3'd3, 5'b00100};  6'd21: morse_lut = {3'd4, 5'b01000};
      6'd22: morse_lut = {3'd3, 5'b00110};  6'd23: morse_lut = {3'd4, 5'b01001};
      6'd24: morse_lut = {3'd4, 5'b01101};  6'd25: morse_lut = {3'd4, 5'b00011};
      6'd26: morse_lut = {3'd5, 5'b11111};  6'd27: morse_lut = {3'd5, 5'b11110};
      6'd28: morse_lut = {3'd5, 5'b11100};  6'd29: morse_lut = {3'd5, 5'b11000};
      6'd30: morse_lut = {3'd5, 5'b10000};  6'd31: morse_lut = {3'd5, 5'b00000};
      6'd32: morse_lut = {3'd5, 5'b00001};  6'd33: morse_lut = {3'd5, 5'b00011};
      6'd34: morse_lut = {3'd5, 5'b00111};  6'd35: morse_lut = {3'd5, 5'b01111};
      default: morse_lut = 8'd0;
    endcase
  endfunction

  // ---------------- PS/2 receiver (pins are only ever read) ----------------
  logic [1:0]        r_clk_sync;
  logic [1:0]        r_data_sync;
  logic              r_clk_prev;
  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [c_TO_W-1:0] r_to_cnt;
  logic [7:0]        r_rx_data;
  logic              r_rx_strb;
  logic              w_fall;
  logic              w_bit;

  assign w_fall = r_clk_prev & ~r_clk_sync[1];
  assign w_bit  = r_data_sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], ps2_clk};
      r_data_sync <= {r_data_sync[0], ps2_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'd0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
      r_rx_data <= 8'd0;
      r_rx_strb <= 1'b0;
    end else begin
      r_rx_strb <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd0) begin
          if (!w_bit) r_bit_cnt <= 4'd1;
        end else if (r_bit_cnt <= 4'd8) begin
          r_shift   <= {w_bit, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end else if (r_bit_cnt == 4'd9) begin
          r_parity  <= w_bit;
          r_bit_cnt <= 4'd10;
        end else begin
          r_bit_cnt <= 4'd0;
          if (w_bit && (^{r_shift, r_parity})) begin
            r_rx_data <= r_shift;
            r_rx_strb <= 1'b1;
          end
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == c_T_TIMEOUT) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
      end
    end
  end

  // ---------------- Decoder and character FIFO ----------------
  logic               r_release;
  logic               r_extended;
  logic [5:0]         r_mem [BUFFER_LENGTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [2:0]         r_state;
  logic [6:0]         w_code;
  logic               w_live;
  logic               w_enter;
  logic               w_push;
  logic               w_pop;

  assign w_code  = scan_to_idx(r_rx_data);
  assign w_live  = r_rx_strb && !r_release && !r_extended &&
                   (r_rx_data != c_KEY_BREAK) && (r_rx_data != c_KEY_EXT) &&
                   (r_state == c_ST_IDLE);
  assign w_enter = w_live && (r_rx_data == c_KEY_ENTER) && (r_count != '0);
  assign w_push  = w_live && w_code[6] && (r_count != c_FULL);
  assign w_pop   = (r_state == c_ST_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_release  <= 1'b0;
      r_extended <= 1'b0;
    end else if (r_rx_strb) begin
      if (r_rx_data == c_KEY_BREAK) begin
        r_release <= 1'b1;
      end else if (r_rx_data == c_KEY_EXT) begin
        r_extended <= 1'b1;
      end else begin
        r_release  <= 1'b0;
        r_extended <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_code[5:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
        r_count  <= r_count + c_CNT_W'(1);
      end else if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
        r_count  <= r_count - c_CNT_W'(1);
      end
    end
  end

  // ---------------- Morse keyer ----------------
  logic [5:0]         w_head;
  logic [7:0]         w_lut;
  logic [c_TMR_W-1:0] r_timer;
  logic [4:0]         r_pat;
  logic [2:0]         r_remain;
  logic               r_dit;
  logic               r_dah;

  assign w_head = r_mem[r_rd_ptr];
  assign w_lut  = morse_lut(w_head);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_ST_IDLE;
      r_timer  <= '0;
      r_pat    <= 5'd0;
      r_remain <= 3'd0;
      r_dit    <= 1'b0;
      r_dah    <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_enter) r_state <= c_ST_LOAD;
        end
        c_ST_LOAD: begin
          if (w_head == c_SPACE) begin
            r_timer <= c_T_WORDGAP;
            r_state <= c_ST_WORDGAP;
          end else begin
            r_dah    <= w_lut[0];
            r_dit    <= ~w_lut[0];
            r_timer  <= w_lut[0] ? c_T_DAH : c_T_DIT;
            r_pat    <= {1'b0, w_lut[4:1]};
            r_remain <= w_lut[7:5] - 3'd1;
            r_state  <= c_ST_ELEMENT;
          end
        end
        c_ST_ELEMENT: begin
          if (r_timer == '0) begin
            r_dit   <= 1'b0;
            r_dah   <= 1'b0;
            r_timer <= c_T_DIT;
            r_state <= c_ST_ELEMGAP;
          end else begin
            r_timer <= r_timer - c_TMR_W'(1);
          end
        end
        c_ST_ELEMGAP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - c_TMR_W'(1);
          end else if (r_remain != 3'd0) begin
            r_dah    <= r_pat[0];
            r_dit    <= ~r_pat[0];
            r_timer  <= r_pat[0] ? c_T_DAH : c_T_DIT;
            r_pat    <= {1'b0, r_pat[4:1]};
            r_remain <= r_remain - 3'd1;
            r_state  <= c_ST_ELEMENT;
          end else begin
            r_timer <= c_T_CHARGAP;
            r_state <= c_ST_CHARGAP;
          end
        end
        c_ST_CHARGAP, c_ST_WORDGAP: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - c_TMR_W'(1);
          end else begin
            r_state <= (r_count != '0) ? c_ST_LOAD : c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.ps2_received_data      = r_rx_data;
  assign bus.ps2_received_data_strb = r_rx_strb;
  assign bus.dit_out                = r_dit;
  assign bus.dah_out                = r_dah;
  assign bus.morse_code_out         = r_dit | r_dah;

endmodule
`default_nettype wire

// File: tb/tb_ps2_morse_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// Module   : tb_ps2_morse_encoder
// Brief    : Randomised PS/2 key stimulus against a string-level Morse model.
// Revision : 1.0
// ============================================================
module tb_ps2_morse_encoder;
  localparam int BUF_LEN = 10;
  localparam int UNIT    = 8;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk_drv = 1'b1;
  logic ps2_data_drv = 1'b1;
  wire  ps2_clk_pin;
  wire  ps2_data_pin;
  assign ps2_clk_pin  = ps2_clk_drv;
  assign ps2_data_pin = ps2_data_drv;

  ps2_morse_encoder_if bus_if ();

  ps2_morse_encoder #(
    .BUFFER_LENGTH (BUF_LEN),
    .UNIT_CYCLES   (UNIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk_pin),
    .ps2_data(ps2_data_pin),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit is_gap;
    int kind;     // 1 dit, 2 dah, 0 gap
    int cycles;
  } run_t;

  run_t       exp_runs[$];
  logic [7:0] exp_bytes[$];
  string      morse_of[logic [7:0]];
  logic [7:0] char_codes[$];
  logic [7:0] ignored_codes[3] = '{8'h0C, 8'h05, 8'h76};

  string      model_q[$];
  bit         model_rel, model_ext, model_playing;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_char(input logic [7:0] code, input string pat);
    morse_of[code] = pat;
    if (pat != " ") char_codes.push_back(code);
  endfunction

  function automatic int total_cycles();
    int s = 0;
    foreach (exp_runs[i]) s += exp_runs[i].cycles;
    return s;
  endfunction

  // Expands queued characters into timed high/low runs using unit arithmetic.
  function automatic void start_playback();
    int   pending = -1;
    run_t r;
    foreach (model_q[c]) begin
      if (model_q[c] == " ") begin
        if (pending >= 0) pending += 4 * UNIT;
      end else begin
        for (int i = 0; i < model_q[c].len(); i++) begin
          if (pending >= 0) begin
            r.is_gap = 1'b1; r.kind = 0; r.cycles = pending;
            exp_runs.push_back(r);
          end
          r.is_gap = 1'b0;
          r.kind   = (model_q[c][i] == "-") ? 2 : 1;
          r.cycles = (r.kind == 2) ? 3 * UNIT : UNIT;
          exp_runs.push_back(r);
          pending = UNIT;
        end
        pending = 3 * UNIT;
      end
    end
    model_q.delete();
    model_playing = 1'b1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hF0) model_rel = 1'b1;
    else if (b == 8'hE0) model_ext = 1'b1;
    else if (model_rel || model_ext) begin
      model_rel = 1'b0;
      model_ext = 1'b0;
    end else if (!model_playing) begin
      if (b == 8'h5A) begin
        if (model_q.size() > 0) start_playback();
      end else if (morse_of.exists(b) && model_q.size() < BUF_LEN) begin
        model_q.push_back(morse_of[b]);
      end
    end
  endfunction

  task automatic ps2_bit(input logic v);
    ps2_data_drv = v;
    repeat (HALF) @(negedge clk);
    ps2_clk_drv = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk_drv = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data_drv = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    last_good = b;
    model_byte(b);
    send_frame(b, 1'b0);
  endtask

  task automatic wait_play_done();
    int n = 0;
    while (exp_runs.size() > 0 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("playback_complete", exp_runs.size(), 0);
    exp_runs.delete();
    repeat ((4 * BUF_LEN + 8) * UNIT) @(negedge clk);
    model_playing = 1'b0;
  endtask

  // Strobe scoreboard plus per-cycle output invariants.
  always @(negedge clk) begin
    if (rst) begin
      check("dit_dah_exclusive", int'(bus_if.dit_out & bus_if.dah_out), 0);
      check("morse_is_or", int'(bus_if.morse_code_out),
            int'(bus_if.dit_out | bus_if.dah_out));
      if (bus_if.ps2_received_data_strb) begin
        if (exp_bytes.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          check("rx_byte", int'(bus_if.ps2_received_data), int'(exp_bytes.pop_front()));
        end
      end
    end
  end

  // Keying monitor: measures runs of dit/dah/low and compares with the model.
  int cur_kind = 0;
  int run_len  = 0;
  always @(negedge clk) begin : mon_morse
    int   k;
    run_t e;
    if (!rst) begin
      cur_kind = 0;
      run_len  = 0;
    end else begin
      k = bus_if.dah_out ? 2 : (bus_if.dit_out ? 1 : 0);
      if (k != cur_kind) begin
        if (cur_kind != 0) begin
          tests++;
          if (exp_runs.size() == 0 || exp_runs[0].is_gap) begin
            fails++;
            $display("FAIL element_unexpected: kind %0d len %0d", cur_kind, run_len);
          end else begin
            e = exp_runs.pop_front();
            if (e.kind != cur_kind || run_len > e.cycles + 1 || run_len < e.cycles - 1) begin
              fails++;
              $display("FAIL element: kind %0d len %0d, expected kind %0d len %0d",
                       cur_kind, run_len, e.kind, e.cycles);
            end
          end
          run_len = 0;
        end
        if (k != 0) begin
          if (exp_runs.size() == 0) begin
            check("element_start_unexpected", 1, 0);
          end else if (exp_runs[0].is_gap) begin
            e = exp_runs.pop_front();
            tests++;
            if (run_len > e.cycles + 1 || run_len < e.cycles - 1) begin
              fails++;
              $display("FAIL gap: len %0d, expected %0d", run_len, e.cycles);
            end
          end
        end
        cur_kind = k;
        run_len  = 1;
      end else begin
        run_len++;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    add_char(8'h1C, ".-");    add_char(8'h32, "-...");  add_char(8'h21, "-.-.");
    add_char(8'h23, "-..");   add_char(8'h24, ".");     add_char(8'h2B, "..-.");
    add_char(8'h34, "--.");   add_char(8'h33, "....");  add_char(8'h43, "..");
    add_char(8'h3B, ".---");  add_char(8'h42, "-.-");   add_char(8'h4B, ".-..");
    add_char(8'h3A, "--");    add_char(8'h31, "-.");    add_char(8'h44, "---");
    add_char(8'h4D, ".--.");  add_char(8'h15, "--.-");  add_char(8'h2D, ".-.");
    add_char(8'h1B, "...");   add_char(8'h2C, "-");     add_char(8'h3C, "..-");
    add_char(8'h2A, "...-");  add_char(8'h1D, ".--");   add_char(8'h22, "-..-");
    add_char(8'h35, "-.--");  add_char(8'h1A, "--..");
    add_char(8'h45, "-----"); add_char(8'h16, ".----"); add_char(8'h1E, "..---");
    add_char(8'h26, "...--"); add_char(8'h25, "....-"); add_char(8'h2E, ".....");
    add_char(8'h36, "-...."); add_char(8'h3D, "--..."); add_char(8'h3E, "---..");
    add_char(8'h46, "----.");
    add_char(8'h29, " ");

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_data", int'(bus_if.ps2_received_data), 0);
    check("reset_strb", int'(bus_if.ps2_received_data_strb), 0);
    check("reset_dit", int'(bus_if.dit_out), 0);
    check("reset_dah", int'(bus_if.dah_out), 0);
    check("reset_morse", int'(bus_if.morse_code_out), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame, then a parity-corrupted copy that must be discarded
    send_byte(8'h1C);
    send_frame(8'h1C, 1'b1);
    check("data_after_bad_parity", int'(bus_if.ps2_received_data), int'(last_good));
    send_byte(8'h5A);
    wait_play_done();

    // A, space, B, Enter
    send_byte(8'h1C); send_byte(8'h29); send_byte(8'h32); send_byte(8'h5A);
    wait_play_done();

    // Break-prefixed key and an unmapped code enqueue nothing
    send_byte(8'hF0); send_byte(8'h21); send_byte(8'h0C); send_byte(8'h5A);
    wait_play_done();

    // Abandoned partial frame followed by a clean one
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data_drv = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    send_byte(8'h32);
    send_byte(8'hE0); send_byte(8'h1C); send_byte(8'h24);
    send_byte(8'h5A);
    wait_play_done();

    // 19 characters: only the first BUF_LEN are keyed
    for (int i = 0; i < 19; i++)
      send_byte(char_codes[$urandom_range(0, char_codes.size() - 1)]);
    send_byte(8'h5A);
    if (total_cycles() > 600) send_byte(char_codes[$urandom_range(0, char_codes.size() - 1)]);
    wait_play_done();

    // Randomised key mixes
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        int sel = $urandom_range(0, 99);
        if (sel < 65) send_byte(char_codes[$urandom_range(0, char_codes.size() - 1)]);
        else if (sel < 75) send_byte(8'h29);
        else if (sel < 85) send_byte(ignored_codes[$urandom_range(0, 2)]);
        else begin
          send_byte((sel < 93) ? 8'hF0 : 8'hE0);
          send_byte(char_codes[$urandom_range(0, char_codes.size() - 1)]);
        end
      end
      send_byte(8'h5A);
      wait_play_done();
    end

    // Reset in the middle of a dah
    send_byte(8'h2C);
    send_byte(8'h5A);
    n = 0;
    while (!bus_if.dah_out && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("dah_seen_before_reset", int'(bus_if.dah_out), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_dit", int'(bus_if.dit_out), 0);
    check("midreset_dah", int'(bus_if.dah_out), 0);
    check("midreset_morse", int'(bus_if.morse_code_out), 0);
    check("midreset_data", int'(bus_if.ps2_received_data), 0);
    exp_runs.delete();
    model_q.delete();
    model_rel = 1'b0;
    model_ext = 1'b0;
    model_playing = 1'b0;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h5A);
    repeat (20 * UNIT) @(negedge clk);

    check("pending_strobes", exp_bytes.size(), 0);
    check("pending_runs", exp_runs.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ps2_morse_encoder.md
# ps2_morse_encoder

Receives PS/2 keyboard frames, decodes scan-code set 2 make codes into characters, queues them in a bounded buffer, and keys them out as Morse code when Enter is pressed. It combines the PS/2 receiver front end with the character-buffer and Morse keying back end. It sits between the keyboard connector pins and the Morse indicator and keyer outputs.

## Interface
- BUFFER_LENGTH, 10: number of character slots in the queue.
- UNIT_CYCLES, 25000: length of one Morse time unit in clk cycles (0.5 ms at 50 MHz).
- TIMEOUT_CYCLES, 100000: idle clk cycles (2 ms) after which a partial PS/2 frame is abandoned.
- clk  input  1  system clock, 50 MHz nominal.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  inout  1  PS/2 clock from the device; the block never drives it (constant high-Z).
- ps2_data  inout  1  PS/2 data from the device; the block never drives it (constant high-Z).
- ps2_received_data  output  8  last valid received byte.
- ps2_received_data_strb  output  1  one-cycle pulse when ps2_received_data is updated.
- dit_out  output  1  high for the duration of each dit element.
- dah_out  output  1  high for the duration of each dah element.
- morse_code_out  output  1  keying signal, equal to dit_out OR dah_out.

## Operation
- Receiver input stage:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - The receiver samples data on each synchronised falling edge of ps2_clk.
- Frame format: 11 bits, in this order:
  - start bit = 0;
  - 8 data bits, LSB first;
  - odd parity bit (data plus parity contain an odd number of 1s);
  - stop bit = 1.
- Frame error: a bad start, parity or stop bit discards the frame. No strobe is issued and ps2_received_data is unchanged.
- Frame timeout: if no falling edge arrives for TIMEOUT_CYCLES in the middle of a frame, the bit counter returns to idle.
- Decoder, applied to each strobed byte:
  - 0xF0 (break prefix): sets the release flag. The next non-prefix byte is discarded and the flag is cleared.
  - 0xE0 (extended prefix): sets the extended flag. The next non-prefix byte is discarded. 0xF0 after 0xE0 also sets the release flag.
  - 0x5A (Enter): starts playback if the queue is non-empty; otherwise it is ignored.
  - 0x29 (space): enqueues SPACE.
  - Set-2 make codes for A–Z and 0–9: enqueue that character.
  - Any other code (for example 0x0C, F4) is ignored.
- Queue:
  - FIFO of BUFFER_LENGTH entries holding 6-bit character indices.
  - An enqueue while the queue is full is dropped.
  - Every byte received during playback is ignored, apart from prefix tracking.
- Playback: dequeues characters in order until the queue is empty, then returns to IDLE.
- Morse element timing (standard ITU codes; A = .-, B = -..., C = -.-.):
  - dit = 1 unit high;
  - dah = 3 units high;
  - gap between elements of one character = 1 unit low;
  - gap after each letter or digit = 3 units low;
  - SPACE = 4 further units low, giving a 7-unit word gap.
- Keyer state machine:
  - IDLE --Enter & non-empty--> LOAD
  - LOAD --> ELEMENT (SPACE goes to WORDGAP)
  - ELEMENT --> ELEMGAP
  - ELEMGAP --> ELEMENT while elements remain, else CHARGAP
  - CHARGAP / WORDGAP --> LOAD if the queue is non-empty, else IDLE
- Reset values: all outputs 0, queue empty, flags clear, state IDLE, ps2_received_data = 0x00. Reset at any point, including mid-frame or mid-playback, aborts the operation immediately.

## Timing
- ps2_received_data_strb:
  - pulses for exactly 1 clk, no later than 4 clk after the ps2_clk falling edge of the stop bit reaches the pin;
  - ps2_received_data is valid in the same cycle and holds until the next valid frame.
- The decoder acts on the strobe cycle; the enqueue is visible the next cycle.
- The first element of playback starts no later than 3 clk after the Enter strobe.
- Element and gap lengths are exact multiples of UNIT_CYCLES, each ±1 clk.
- dit_out and dah_out are never high together.
- morse_code_out is combinational from registered dit_out and dah_out, so it has no additional latency.

## Test plan
- Single frame 0x1C, ps2_clk period 80 µs → one strobe with ps2_received_data = 0x1C; queue count becomes 1.
- Frame for 0x1C with the parity bit flipped to 1 → no strobe; data register unchanged.
- Keys A, space, B, then Enter (0x5A), with UNIT_CYCLES = 25000:
  - dit 1u, gap 1u, dah 3u, gap 7u;
  - then dah 3u and dits 1u (B = -...), each separated by 1u gaps;
  - then IDLE.
  - morse_code_out mirrors dit_out OR dah_out throughout.
- Break sequence 0xF0, 0x21, followed by 0x0C (F4) → nothing enqueued; a following Enter stays in IDLE.
- 19 character codes followed by Enter → only the first 10 characters are keyed; the remainder are dropped.
- rst asserted low mid-dah → all outputs 0 immediately; after release, a new Enter with an empty queue produces no output.
